// File: rtl/mips_data_mem.sv
// mips_data_mem
//   Data-memory responder for the 5-stage MIPS core's mem_* interface.
//   After every reset a clear sweep writes zero to every word, one word per
//   clock, while init_busy is high and core accesses are ignored. Once the
//   sweep finishes the block serves combinational reads and posedge writes.
//   Misaligned or out-of-range accesses are dropped and set a sticky addr_err.
//
// Optional feature macro: DMEM_STATS_EN adds saturating read/write counters.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-high
//   mem_ren    in   1   read enable from core
//   mem_wen    in   1   write enable from core
//   mem_addr   in   32  byte address from core
//   mem_dout   in   32  write data from core
//   mem_din    out  32  read data to core (0 when no valid read)
//   init_busy  out  1   clear sweep in progress
//   addr_err   out  1   sticky misaligned/out-of-range flag
//   rd_count   out  32  accepted reads   (DMEM_STATS_EN only)
//   wr_count   out  32  accepted writes  (DMEM_STATS_EN only)
module mips_data_mem #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        init_busy,
    output logic        addr_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [31:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  addr_err_q, addr_err_d;

    // Address decode relative to BASE_ADDR; subtraction wraps on purpose so
    // addresses below the base land far out of range.
    logic [31:0]           off;
    logic                  aligned, in_range, ready;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  rd_ok, wr_ok, bad_acc;

    assign off      = mem_addr - BASE_ADDR;
    assign aligned  = (off[1:0] == 2'b00);
    assign in_range = (off[31:ADDR_WIDTH+2] == '0);
    assign idx      = off[ADDR_WIDTH+1:2];
    assign ready    = (state_q == ST_READY);

    assign rd_ok   = ready & mem_ren & aligned & in_range;
    assign wr_ok   = ready & mem_wen & aligned & in_range;
    assign bad_acc = ready & (mem_ren | mem_wen) & ~(aligned & in_range);

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        addr_err_d = addr_err_q | bad_acc;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            // The edge that clears the last word also leaves the sweep.
            if (clr_ptr_q == '1) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Single write port shared by the sweep and the core.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    assign mem_we    = ready ? wr_ok : 1'b1;
    assign mem_waddr = ready ? idx : clr_ptr_q;
    assign mem_wdata = ready ? mem_dout : 32'h0;

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    // Combinational read sees the pre-edge word, giving read-before-write
    // when the core reads and writes the same word in one cycle.
    assign mem_din   = rd_ok ? mem[idx] : 32'h0;
    assign init_busy = ~ready;
    assign addr_err  = addr_err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_ok && rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
        if (wr_ok && wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: a word-array model with a sweep countdown is
// updated on every clock and compared against the DUT on every falling edge;
// directed steps add literal expectations on top.
module tb_mips_data_mem;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_dout = 32'h0;
    logic [31:0] mem_din;
    logic        init_busy;
    logic        addr_err;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    mips_data_mem #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .init_busy (init_busy),
        .addr_err  (addr_err)
`ifdef DMEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_busy_left = DEPTH;
    bit          m_err = 1'b0;
    longint      m_rd = 0, m_wr = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(DEPTH * 4));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy_left = DEPTH;
            m_err = 1'b0;
            m_rd = 0;
            m_wr = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            if ((mem_ren || mem_wen) && !addr_ok(mem_addr)) m_err = 1'b1;
            if (mem_ren && addr_ok(mem_addr) && m_rd < 64'hFFFF_FFFF) m_rd++;
            if (mem_wen && addr_ok(mem_addr)) begin
                if (m_wr < 64'hFFFF_FFFF) m_wr++;
                m_mem[mem_addr / 4] = mem_dout;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_din;
        bit          busy;
        busy = rst || (m_busy_left > 0);
        exp_din = (!busy && mem_ren && addr_ok(mem_addr)) ? m_mem[mem_addr / 4] : 32'h0;
        check("cyc_init_busy", {31'h0, init_busy}, {31'h0, busy});
        check("cyc_addr_err", {31'h0, addr_err}, {31'h0, m_err});
        check("cyc_mem_din", mem_din, exp_din);
`ifdef DMEM_STATS_EN
        check("cyc_rd_count", rd_count, m_rd[31:0]);
        check("cyc_wr_count", wr_count, m_wr[31:0]);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        mem_ren = ren;
        mem_wen = wen;
        mem_addr = a;
        mem_dout = d;
        #1;
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, 32'(n), 32'd1024);
    endtask

    initial begin
        // Reset and first sweep
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("reset_busy", {31'h0, init_busy}, 32'h1);
        check("reset_err", {31'h0, addr_err}, 32'h0);
        count_busy("sweep_len");

        drive(1, 0, 32'h0, 32'h0);
        check("rd_0x0", mem_din, 32'h0);
        drive(1, 0, 32'hFFC, 32'h0);
        check("rd_0xffc", mem_din, 32'h0);

        // Write then read back
        drive(0, 1, 32'h10, 32'hDEAD_BEEF);
        drive(1, 0, 32'h10, 32'h0);
        check("rd_0x10", mem_din, 32'hDEAD_BEEF);
        check("err_clean", {31'h0, addr_err}, 32'h0);

        // Read-before-write
        drive(0, 1, 32'h20, 32'h1111_1111);
        drive(1, 1, 32'h20, 32'h2222_2222);
        check("rbw_old", mem_din, 32'h1111_1111);
        drive(1, 0, 32'h20, 32'h0);
        check("rbw_new", mem_din, 32'h2222_2222);

        // Last word boundary
        drive(0, 1, 32'hFFC, 32'hA5A5_5A5A);
        drive(1, 0, 32'hFFC, 32'h0);
        check("rd_last", mem_din, 32'hA5A5_5A5A);

        // Misaligned write: dropped, error set on that edge
        drive(0, 1, 32'h13, 32'h0BAD_0BAD);
        check("err_before_edge", {31'h0, addr_err}, 32'h0);
        drive(1, 0, 32'h10, 32'h0);
        check("rd_0x10_kept", mem_din, 32'hDEAD_BEEF);
        check("err_set", {31'h0, addr_err}, 32'h1);

        // Out-of-range read
        drive(1, 0, 32'h1000, 32'h0);
        check("rd_oor", mem_din, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        check("err_sticky", {31'h0, addr_err}, 32'h1);

        // Reset, then reset again mid-sweep
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (500) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midrst_err", {31'h0, addr_err}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 count_busy("resweep_len");
        drive(1, 0, 32'h10, 32'h0);
        check("cleared_0x10", mem_din, 32'h0);
        drive(1, 0, 32'h20, 32'h0);
        check("cleared_0x20", mem_din, 32'h0);

`ifdef DMEM_STATS_EN
        // Fresh counters: restart from reset
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("cnt_rst_rd", rd_count, 32'h0);
        check("cnt_rst_wr", wr_count, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 count_busy("stats_sweep_len");
        drive(0, 1, 32'h40, 32'h1);
        drive(0, 1, 32'h44, 32'h2);
        drive(0, 1, 32'h48, 32'h3);
        drive(1, 0, 32'h40, 32'h0);
        drive(1, 0, 32'h44, 32'h0);
        drive(1, 0, 32'h44, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        check("cnt_wr", wr_count, 32'd3);
        check("cnt_rd", rd_count, 32'd3);
`endif

        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
